gelato_reconv_stack: RTL

GELATO_RECONV_STACK -- requirements
Module: gelato_reconv_stack

---
 rtl/gelato_reconv_stack.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/gelato_reconv_stack.sv
// Per-warp SIMT reconvergence stack: tracks PC and active mask of each warp
// across divergent branches, popping back to the post-dominator on reconvergence.
module gelato_reconv_stack #(
  parameter int WARP_NUM   = 4,
  parameter int THREAD_NUM = 32,
  parameter int DEPTH      = 8,
  parameter int PC_WIDTH   = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rdy,
  input  logic                                 init_valid,
  input  logic [PC_WIDTH-1:0]                  init_pc,
  input  logic [$clog2(WARP_NUM*THREAD_NUM):0] init_workers,
  input  logic                                 upd_valid,
  input  logic [$clog2(WARP_NUM)-1:0]          upd_warp,
  input  logic [1:0]                           upd_kind,
  input  logic [PC_WIDTH-1:0]                  upd_pc,
  input  logic [PC_WIDTH-1:0]                  upd_taken_pc,
  input  logic [THREAD_NUM-1:0]                upd_taken_mask,
  input  logic [PC_WIDTH-1:0]                  upd_reconv_pc,
  output logic [WARP_NUM-1:0]                  warp_valid,
  output logic [WARP_NUM*PC_WIDTH-1:0]         warp_pc,
  output logic [WARP_NUM*THREAD_NUM-1:0]       warp_mask,
  output logic [WARP_NUM-1:0]                  overflow,
  output logic                                 act_valid,
  output logic [$clog2(WARP_NUM)-1:0]          act_warp
);

  localparam int IW  = $clog2(WARP_NUM*THREAD_NUM) + 1;
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IXW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    K_SEQ  = 2'd0,
    K_BR   = 2'd1,
    K_EXIT = 2'd2,
    K_RSV  = 2'd3
  } kind_e;

  logic [SPW-1:0]        sp_q    [WARP_NUM];
  logic [PC_WIDTH-1:0]   pc_q    [WARP_NUM][DEPTH];
  logic [PC_WIDTH-1:0]   rpc_q   [WARP_NUM][DEPTH];
  logic [THREAD_NUM-1:0] mask_q  [WARP_NUM][DEPTH];

  logic [PC_WIDTH-1:0]   top_pc   [WARP_NUM];
  logic [PC_WIDTH-1:0]   top_rpc  [WARP_NUM];
  logic [THREAD_NUM-1:0] top_mask [WARP_NUM];

  for (genvar g = 0; g < WARP_NUM; g++) begin : g_warp
    logic [IXW-1:0] ti;
    assign ti          = IXW'(sp_q[g] - SPW'(1));
    assign top_pc[g]   = pc_q[g][ti];
    assign top_rpc[g]  = rpc_q[g][ti];
    assign top_mask[g] = mask_q[g][ti];
    assign warp_valid[g] = |sp_q[g];
    assign warp_pc[g*PC_WIDTH +: PC_WIDTH]       = top_pc[g];
    assign warp_mask[g*THREAD_NUM +: THREAD_NUM] = top_mask[g];
  end

  // Launch: split the worker count into full warps plus one partial warp.
  logic [IW-1:0]         init_w;
  logic [IW-1:0]         init_r;
  logic [THREAD_NUM-1:0] init_mask [WARP_NUM];

  assign init_w = IW'(init_workers / IW'(THREAD_NUM));
  assign init_r = IW'(init_workers % IW'(THREAD_NUM));

  always_comb begin
    for (int i = 0; i < WARP_NUM; i++) begin
      init_mask[i] = '0;
      if (IW'(i) < init_w)
        init_mask[i] = '1;
      else if (IW'(i) == init_w)
        init_mask[i] = ~({THREAD_NUM{1'b1}} << init_r);
    end
  end

  kind_e                 kind;
  logic [SPW-1:0]        sp_w;
  logic [PC_WIDTH-1:0]   cur_rpc;
  logic [THREAD_NUM-1:0] cur_mask;
  logic [THREAD_NUM-1:0] t_mask;
  logic [THREAD_NUM-1:0] n_mask;
  logic [IXW-1:0]        tix;
  logic [IXW-1:0]        p0;
  logic [IXW-1:0]        p1;

  assign kind     = kind_e'(upd_kind);
  assign sp_w     = sp_q[upd_warp];
  assign cur_rpc  = top_rpc[upd_warp];
  assign cur_mask = top_mask[upd_warp];
  assign t_mask   = upd_taken_mask & cur_mask;
  assign n_mask   = cur_mask & ~t_mask;
  assign tix      = IXW'(sp_w - SPW'(1));
  assign p0       = IXW'(sp_w);
  assign p1       = IXW'(sp_w + SPW'(1));

  logic [SPW-1:0]      nxt_sp;
  logic                set_pc;
  logic [PC_WIDTH-1:0] new_pc;
  logic                push;
  logic                ovf_set;
  logic                pop_act;

  always_comb begin
    nxt_sp  = sp_w;
    set_pc  = 1'b0;
    new_pc  = upd_pc;
    push    = 1'b0;
    ovf_set = 1'b0;
    pop_act = 1'b0;
    if (upd_valid && sp_w != '0) begin
      case (kind)
        K_SEQ: begin
          if (upd_pc == cur_rpc) begin
            nxt_sp  = sp_w - SPW'(1);
            pop_act = sp_w > SPW'(1);
          end else begin
            set_pc = 1'b1;
          end
        end
        K_BR: begin
          if (t_mask == '0) begin
            set_pc = 1'b1;
          end else if (n_mask == '0) begin
            set_pc = 1'b1;
            new_pc = upd_taken_pc;
          end else if (sp_w > SPW'(DEPTH - 2)) begin
            ovf_set = 1'b1;
          end else begin
            set_pc = 1'b1;
            new_pc = upd_reconv_pc;
            push   = 1'b1;
            nxt_sp = sp_w + SPW'(2);
          end
        end
        K_EXIT: begin
          nxt_sp  = sp_w - SPW'(1);
          pop_act = sp_w > SPW'(1);
        end
        K_RSV: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WARP_NUM; i++)
        sp_q[i] <= '0;
      overflow  <= '0;
      act_valid <= 1'b0;
      act_warp  <= '0;
    end else if (rdy) begin
      if (init_valid) begin
        for (int i = 0; i < WARP_NUM; i++)
          sp_q[i] <= (|init_mask[i]) ? SPW'(1) : '0;
        overflow  <= '0;
        act_valid <= 1'b0;
      end else begin
        sp_q[upd_warp] <= nxt_sp;
        if (ovf_set)
          overflow[upd_warp] <= 1'b1;
        act_valid <= pop_act;
        if (pop_act)
          act_warp <= upd_warp;
      end
    end
  end

  // Entry payload needs no reset: only slots below sp are ever observed.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (init_valid) begin
        for (int i = 0; i < WARP_NUM; i++) begin
          pc_q[i][0]   <= init_pc;
          rpc_q[i][0]  <= '1;
          mask_q[i][0] <= init_mask[i];
        end
      end else begin
        if (set_pc)
          pc_q[upd_warp][tix] <= new_pc;
        if (push) begin
          pc_q[upd_warp][p0]   <= upd_pc;
          rpc_q[upd_warp][p0]  <= upd_reconv_pc;
          mask_q[upd_warp][p0] <= n_mask;
          pc_q[upd_warp][p1]   <= upd_taken_pc;
          rpc_q[upd_warp][p1]  <= upd_reconv_pc;
          mask_q[upd_warp][p1] <= t_mask;
        end
      end
    end
  end

endmodule
